// File: rtl/present_round_ctrl.sv
// 16-bit PRESENT-style cipher controller: one round per cycle, then post-whitening.
// Latency ROUNDS+1 cycles accept-to-out_valid; result held in DONE until out_ready, no new job accepted meanwhile.
module present_round_ctrl #(
    parameter int unsigned ROUNDS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_in,
    input  logic [31:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out,
    output logic        busy
);

    localparam logic [4:0] LP_ROUNDS = 5'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_blk;
    logic [31:0] r_key;
    logic [4:0]  r_rc;

    logic        w_accept;
    logic        w_last_round;
    logic [15:0] w_ark;
    logic [15:0] w_sub;
    logic [15:0] w_round_blk;
    logic [31:0] w_key_rot;
    logic [31:0] w_key_nxt;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Output bit j takes input bit (4*j mod 15), the inverse of i -> 4*i mod 15.
    function automatic logic [15:0] player(input logic [15:0] s);
        return {s[15], s[11], s[7], s[3],
                s[14], s[10], s[6], s[2],
                s[13], s[9],  s[5], s[1],
                s[12], s[8],  s[4], s[0]};
    endfunction

    assign w_accept     = in_valid & in_ready;
    assign w_last_round = (r_rc == LP_ROUNDS);

    assign w_ark       = r_blk ^ r_key[31:16];
    assign w_sub       = {sbox(w_ark[15:12]), sbox(w_ark[11:8]),
                          sbox(w_ark[7:4]),   sbox(w_ark[3:0])};
    assign w_round_blk = player(w_sub);

    assign w_key_rot = {r_key[24:0], r_key[31:25]};
    assign w_key_nxt = {sbox(w_key_rot[31:28]), w_key_rot[27:12],
                        w_key_rot[11:7] ^ r_rc, w_key_rot[6:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ROUND;
            S_ROUND: if (w_last_round) w_state_nxt = S_FINAL;
            S_FINAL: w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    assign data_out = r_blk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk <= '0;
            r_key <= '0;
            r_rc  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_blk <= data_in;
                        r_key <= key_in;
                        r_rc  <= 5'd1;
                    end
                end
                S_ROUND: begin
                    r_blk <= w_round_blk;
                    r_key <= w_key_nxt;
                    if (!w_last_round) r_rc <= r_rc + 5'd1;
                end
                S_FINAL: begin
                    // Post-whitening with the key left by the last round.
                    r_blk <= r_blk ^ r_key[31:16];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_round_ctrl.sv
// Bench for present_round_ctrl: directed vector table, reset/abort sequences and random jobs vs. a reference model.
module tb_present_round_ctrl;

    logic        clk;
    logic        rst_n;
    logic        tb_in_valid;
    logic [15:0] data_in;
    logic [31:0] key_in;
    logic        out_ready;
    int          sel;

    logic        iv1, ir1, ov1, busy1;
    logic        iv15, ir15, ov15, busy15;
    logic [15:0] do1, do15;

    int n_checks;
    int n_fail;

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    assign iv1  = tb_in_valid & (sel == 0);
    assign iv15 = tb_in_valid & (sel == 1);

    present_round_ctrl #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .data_in(data_in), .key_in(key_in), .out_valid(ov1),
        .out_ready(out_ready), .data_out(do1), .busy(busy1)
    );

    present_round_ctrl u_dut15 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv15), .in_ready(ir15),
        .data_in(data_in), .key_in(key_in), .out_valid(ov15),
        .out_ready(out_ready), .data_out(do15), .busy(busy15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic f_ir();  return (sel == 1) ? ir15 : ir1;     endfunction
    function automatic logic f_ov();  return (sel == 1) ? ov15 : ov1;     endfunction
    function automatic logic f_bsy(); return (sel == 1) ? busy15 : busy1; endfunction
    function automatic logic [15:0] f_do(); return (sel == 1) ? do15 : do1; endfunction
    function automatic int f_rounds(); return (sel == 1) ? 15 : 1; endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference cipher written directly from the round/key-schedule rules.
    function automatic logic [15:0] ref_present(input logic [15:0] d, input logic [31:0] k,
                                                input int rounds);
        logic [15:0] s, t, p;
        logic [31:0] key;
        logic [3:0]  nib;
        s   = d;
        key = k;
        for (int r = 1; r <= rounds; r++) begin
            s = s ^ key[31:16];
            t = '0;
            for (int n = 0; n < 4; n++) begin
                nib = 4'((s >> (4 * n)) & 16'hF);
                t   = t | (16'(SBOX[nib]) << (4 * n));
            end
            p = t & 16'h8000;
            for (int i = 0; i < 15; i++) begin
                if (((t >> i) & 16'h1) != 16'h0) p = p | (16'h1 << ((4 * i) % 15));
            end
            s   = p;
            key = (key << 7) | (key >> 25);
            nib = key[31:28];
            key[31:28] = SBOX[nib];
            key[11:7]  = key[11:7] ^ 5'(r);
        end
        return s ^ key[31:16];
    endfunction

    // Called at a negedge with the selected DUT idle; returns at a negedge, DUT idle again.
    task automatic run_job(input logic [15:0] din, input logic [31:0] kin, input int stall,
                           input int pulse_at, input logic [15:0] exp);
        logic [15:0] held;
        int lat;
        bit seen;
        check("in_ready_before_job", f_ir(), 1'b1);
        tb_in_valid = 1'b1;
        data_in     = din;
        key_in      = kin;
        out_ready   = 1'($urandom_range(0, 1));
        @(negedge clk);
        tb_in_valid = 1'b0;
        data_in     = 16'($urandom);
        key_in      = $urandom;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (f_ov()) begin
                seen = 1'b1;
            end else begin
                check("busy_while_running", f_bsy(), 1'b1);
                check("in_ready_while_running", f_ir(), 1'b0);
                tb_in_valid = (lat == pulse_at);
                data_in     = 16'($urandom);
                key_in      = $urandom;
                out_ready   = 1'($urandom_range(0, 1));
                @(negedge clk);
                lat++;
            end
        end
        tb_in_valid = 1'b0;
        check("out_valid_seen", seen, 1'b1);
        check("latency", lat, f_rounds() + 1);
        check("data_out", f_do(), exp);
        held = f_do();
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("out_valid_held", f_ov(), 1'b1);
            check("data_out_held", f_do(), held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", f_ov(), 1'b0);
        check("in_ready_after_hs", f_ir(), 1'b1);
        check("busy_after_hs", f_bsy(), 1'b0);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] din;
        logic [31:0] kin;
        int          stall;
        int          pulse_at;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] d;
        logic [31:0] k;
        int pa;
        n_checks    = 0;
        n_fail      = 0;
        sel         = 0;
        rst_n       = 1'b0;
        tb_in_valid = 1'b0;
        data_in     = '0;
        key_in      = '0;
        out_ready   = 1'b0;

        vecs[0] = '{0, 16'h0000, 32'h0000_0000, 0, -1, 16'h3F00};
        vecs[1] = '{0, 16'hFFFF, 32'h0000_0000, 1, -1, 16'hC0F0};
        vecs[2] = '{0, 16'h0000, 32'hFFFF_0000, 0, -1, 16'h2F70};
        vecs[3] = '{0, 16'h1234, 32'h0000_0000, 2, -1, 16'hFC6B};
        vecs[4] = '{1, 16'h0000, 32'h0000_0000, 5, -1, 16'h0};
        vecs[5] = '{1, 16'hABCD, 32'h0123_4567, 5, -1, 16'h0};
        vecs[6] = '{1, 16'h1234, 32'hDEAD_BEEF, 0, 3, 16'h0};
        vecs[7] = '{1, 16'hFFFF, 32'hFFFF_FFFF, 1, 10, 16'h0};
        for (int i = 4; i < 8; i++) vecs[i].exp = ref_present(vecs[i].din, vecs[i].kin, 15);

        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("rst_in_ready", f_ir(), 1'b1);
            check("rst_out_valid", f_ov(), 1'b0);
            check("rst_busy", f_bsy(), 1'b0);
            check("rst_data_out", f_do(), 16'h0000);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Accept on the first edge after reset release.
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].sel;
            run_job(vecs[i].din, vecs[i].kin, vecs[i].stall, vecs[i].pulse_at, vecs[i].exp);
        end

        // Reset while the 15-round job sits at rc=3.
        sel         = 1;
        tb_in_valid = 1'b1;
        data_in     = 16'h5A5A;
        key_in      = 32'h1357_9BDF;
        @(negedge clk);
        tb_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", ov15, 1'b0);
        check("abort_busy", busy15, 1'b0);
        check("abort_in_ready", ir15, 1'b1);
        check("abort_data_out", do15, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(16'hC3A5, 32'h0F1E_2D3C, 1, -1, ref_present(16'hC3A5, 32'h0F1E_2D3C, 15));

        // Random regression on both round counts.
        for (int j = 0; j < 1200; j++) begin
            sel = (j < 1000) ? 1 : 0;
            d   = 16'($urandom);
            k   = $urandom;
            pa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, f_rounds() - 1) : -1;
            run_job(d, k, $urandom_range(0, 3), pa, ref_present(d, k, f_rounds()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
